tick_divider: RTL
=================

Name: tick_divider

Overview:
- Downstream consumer of the toggle flip-flop divider output (Q); counts its rising edges in the system clock domain.
- Produces a modulo-N edge count, a one-cycle terminal-count pulse and a further-divided square wave.
- The divisor is reloadable at run time through a valid/ready handshake, applied glitch-free at a count boundary.

Parameters:
- WIDTH, 4, width of count, divisor and load bus.
- DEFAULT_DIV, 10, divisor loaded at reset; must be >= 1 and < 2**WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  toggle flip-flop Q, synchronous to clock.
- enable  input  1  count enable.
- load_valid  input  1  new divisor offered.
- load_div  input  WIDTH  divisor value offered.
- load_ready  output  1  divisor register can accept a value.
- count  output  WIDTH  current edge count, 0..divisor-1.
- tc  output  1  one-cycle pulse on wrap.
- div_out  output  1  toggles on every wrap; period = 2*divisor tick_in rising edges.

Behaviour:
- Reset (reset_n low, asynchronous): tick_q=0, count=0, divisor=DEFAULT_DIV, pending=0, tc=0, div_out=0, load_ready=1, load FSM=LOAD_IDLE. Any pending load is discarded.
- Edge detect: tick_q <= tick_in every cycle; edge = tick_in & ~tick_q (combinational).
  - First sample after reset with tick_in=1 counts as an edge.
- Counting, when enable=1 and edge=1:
  - If count == divisor-1: count <= 0, tc <= 1, div_out <= ~div_out.
  - Else: count <= count+1, tc <= 0.
- No edge, or enable=0: count and div_out hold; tc <= 0.
- tc is registered: high exactly one clock, in the cycle after the clock edge that sampled the wrapping edge.
- Divisor rule: effective divisor = max(load_div, 1). A value of 0 is stored as 1. Divisor 1 gives tc on every edge with count fixed at 0.
- Load FSM states:
  - LOAD_IDLE: load_ready=1. When load_valid=1, latch pending <= load_div and go to LOAD_PENDING.
  - LOAD_PENDING: load_ready=0; load_valid is ignored.
  - Leave LOAD_PENDING when either:
    - (a) a wrap occurs: divisor <= pending, count <= 0; or
    - (b) enable=0: divisor <= pending, count <= 0, div_out holds.
  - Next state after (a) or (b): LOAD_IDLE, so load_ready returns to 1 on the following cycle.
- Simultaneous acceptance and wrap in the same cycle: the wrap uses the old divisor; the new value applies at the next wrap.
- Live divisor change: the divisor never changes mid-count while enable=1, so count never exceeds divisor-1.
- Unused inputs: load_div is don't-care when load_valid=0. tick_in toggling while enable=0 does not advance count, but tick_q still tracks it, so no spurious edge when enable rises.
- Mid-operation reset: all outputs return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package tick_divider_pkg:
  - default WIDTH and DEFAULT_DIV constants;
  - load FSM state enum {LOAD_IDLE, LOAD_PENDING}.
- One sub-module, rise_detect: 1-bit registered edge detector.
  - Ports: clock, reset_n, in, out pulse.
  - Reused for other sequential stages.
- The counter and load FSM stay in tick_divider.

Test Plan:
- Reset values: hold reset_n=0 and toggle clock → count=0, tc=0, div_out=0, load_ready=1. Release, enable=1, drive tick_in from the toggle flop → count sequence 0,1,…,9,0. tc pulses one cycle after the 10th rising edge; div_out=1.
- Default period: run 20 rising edges at DEFAULT_DIV=10 → exactly 2 tc pulses. div_out returns to 0, giving a period of 20 edges.
- Load at a boundary: at count=3, load_valid=1 with load_div=4 → load_ready=0 next cycle; counting continues to 9 with the old divisor. After the wrap: divisor=4, count sequence 0,1,2,3,0, load_ready=1.
- Load of 0, and acceptance on a wrap cycle:
  - load_div=0 → stored as 1; tc on every tick_in edge, count stays 0.
  - Offer load_div=5 in the same cycle as a wrap → the old divisor is used for that wrap; divisor 5 takes effect at the next wrap.
- Load while disabled: enable=0, count=6, load_div=3 → one cycle later count=0, divisor=3, load_ready=1.
  - Toggling tick_in while enable=0 leaves count unchanged.
  - Raising enable while tick_in=1 produces no extra count.
- Asynchronous reset mid-operation: pull reset_n low between clock edges at count=7 with a pending load → count=0, divisor=10, div_out=0, load_ready=1 immediately. The pending value is never applied.

Source files
------------

// File: rtl/tick_divider_pkg.sv
// Shared constants and load-FSM state type for the tick_divider edge counter.
package tick_divider_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV   = 10;

    typedef enum logic [0:0] {
        LOAD_IDLE    = 1'b0,
        LOAD_PENDING = 1'b1
    } load_state_e;

endpackage

// File: rtl/tick_divider_rise_detect.sv
// Single-bit rising-edge detector: registers the input and flags a 0->1 transition
// combinationally so the pulse lines up with the cycle the new level is sampled.
module rise_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic din_q_r;

    // Previous-cycle copy of the input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            din_q_r <= 1'b0;
        end else begin
            din_q_r <= din;
        end
    end

    assign pulse = din & ~din_q_r;

endmodule

// File: rtl/tick_divider.sv
// Counts rising edges of a toggle-flop output modulo a run-time reloadable divisor,
// emitting a terminal-count pulse and a further-divided square wave.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_div,
    output logic             load_ready,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);

    localparam logic [WIDTH-1:0] DIV_RESET_C = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE_C       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C      = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] load_clamped_s;
    logic             edge_s;
    logic             wrap_s;
    logic             tc_r;
    logic             div_out_r;
    logic             load_ready_r;
    load_state_e      state_r;

    rise_detect u_rise_detect (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (tick_in),
        .pulse   (edge_s)
    );

    // Wrap decode against the divisor currently in force; zero divisors are stored as one.
    always_comb begin
        load_clamped_s = (load_div == ZERO_C) ? ONE_C : load_div;
        wrap_s         = enable & edge_s & (count_r == (divisor_r - ONE_C));
    end

    // Edge counter plus load FSM; a pending divisor is only swapped in at a wrap or while idle-disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r      <= ZERO_C;
            divisor_r    <= DIV_RESET_C;
            pending_r    <= ZERO_C;
            tc_r         <= 1'b0;
            div_out_r    <= 1'b0;
            load_ready_r <= 1'b1;
            state_r      <= LOAD_IDLE;
        end else begin
            tc_r <= wrap_s;
            if (enable && edge_s) begin
                if (wrap_s) begin
                    count_r   <= ZERO_C;
                    div_out_r <= ~div_out_r;
                end else begin
                    count_r <= count_r + ONE_C;
                end
            end
            case (state_r)
                LOAD_IDLE: begin
                    if (load_valid) begin
                        pending_r    <= load_clamped_s;
                        load_ready_r <= 1'b0;
                        state_r      <= LOAD_PENDING;
                    end
                end
                LOAD_PENDING: begin
                    if (wrap_s || !enable) begin
                        divisor_r    <= pending_r;
                        count_r      <= ZERO_C;
                        load_ready_r <= 1'b1;
                        state_r      <= LOAD_IDLE;
                    end
                end
                default: begin
                    load_ready_r <= 1'b1;
                    state_r      <= LOAD_IDLE;
                end
            endcase
        end
    end

    assign count      = count_r;
    assign tc         = tc_r;
    assign div_out    = div_out_r;
    assign load_ready = load_ready_r;

endmodule
